hilo_div_unit: RTL and testbench



---
 rtl/hilo_div_unit.sv | 134 +++++++++++++
 tb/tb_hilo_div_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div_unit.sv
// Radix-2 restoring divider producing the MIPS HI/LO pair for DIV/DIVU.
// Remainder goes to HI, quotient to LO; a flush can annul an in-flight divide.
module hilo_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             annul_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    typedef enum logic [1:0] {
        IDLE,
        BYZERO,
        ON,
        END
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign a_neg = signed_i & dividend_i[WIDTH-1];
    assign b_neg = signed_i & divisor_i[WIDTH-1];
    // The most negative value negates to itself, which is its correct magnitude.
    assign a_mag = a_neg ? -dividend_i : dividend_i;
    assign b_mag = b_neg ? -divisor_i : divisor_i;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             last;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // One extra bit keeps the trial subtract free of overflow.
    assign rem_sh = {rem, quo[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvs};
    assign last   = (cnt == CNT_W'(WIDTH - 1));
    assign q_fix  = neg_q ? -quo : quo;
    assign r_fix  = neg_r ? -rem : rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            hi_o   <= '0;
            lo_o   <= '0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_i && !annul_i) begin
                        busy_o <= 1'b1;
                        cnt    <= '0;
                        dvs    <= b_mag;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        if (divisor_i == '0) begin
                            // Raw dividend is parked in rem for the HI write.
                            state <= BYZERO;
                            rem   <= dividend_i;
                            quo   <= '0;
                        end else begin
                            state <= ON;
                            rem   <= '0;
                            quo   <= a_mag;
                        end
                    end
                end
                BYZERO: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    if (!annul_i) begin
                        hi_o   <= rem;
                        lo_o   <= '1;
                        done_o <= 1'b1;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        rem <= diff[WIDTH] ? rem_sh[WIDTH-1:0]
                                           : diff[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
                        cnt <= cnt + CNT_W'(1);
                        if (last) begin
                            state <= END;
                        end
                    end
                end
                END: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    if (!annul_i) begin
                        hi_o   <= r_fix;
                        lo_o   <= q_fix;
                        done_o <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Bench for hilo_div_unit: directed MIPS DIV/DIVU cases plus random traffic
// compared every cycle against a transaction-level divide model.
module tb_hilo_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sgn = 1'b0;
    logic         annul = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;

    int checks = 0;
    int passes = 0;
    bit chk_en = 1'b0;

    hilo_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start),
        .signed_i  (sgn),
        .annul_i   (annul),
        .dividend_i(dividend),
        .divisor_i (divisor),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Quotient truncates toward zero, remainder takes the dividend's sign.
    function automatic void ref_div(input logic s, input logic [W-1:0] a,
                                    input logic [W-1:0] b,
                                    output logic [W-1:0] q,
                                    output logic [W-1:0] r);
        longint sa, sb, sq, sr;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[W-1:0];
            r  = sr[W-1:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Transaction model: an accepted op completes after a fixed number of edges.
    logic         m_busy = 1'b0, m_done = 1'b0;
    logic [W-1:0] m_hi = '0, m_lo = '0;
    logic [W-1:0] p_hi = '0, p_lo = '0;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic         m_s = 1'b0;
    int           m_left = 0;

    always @(posedge clk) begin
        logic [W-1:0] q, r;
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (annul) begin
                    m_busy <= 1'b0;
                end else if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_hi   <= p_hi;
                    m_lo   <= p_lo;
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (start && !annul) begin
                ref_div(sgn, dividend, divisor, q, r);
                p_lo   <= q;
                p_hi   <= r;
                m_a    <= dividend;
                m_b    <= divisor;
                m_s    <= sgn;
                m_busy <= 1'b1;
                m_left <= (divisor == '0) ? 1 : W + 1;
            end
        end
    end

    function automatic logic [W-1:0] mag(input logic s, input logic [W-1:0] v);
        return (s && v[W-1]) ? -v : v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'b0, busy_o}, {31'b0, m_busy});
            check("done", {31'b0, done_o}, {31'b0, m_done});
            check("hi", hi_o, m_hi);
            check("lo", lo_o, m_lo);
            if (done_o && m_done && m_b != '0) begin
                check("identity", lo_o * m_b + hi_o, m_a);
                check("rem_bound", {31'b0, mag(m_s, hi_o) < mag(m_s, m_b)},
                      32'd1);
            end
        end
    end

    task automatic do_op(input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, output int lat,
                         output logic [W-1:0] hi, output logic [W-1:0] lo);
        @(posedge clk);
        #1;
        start = 1'b1;
        sgn = s;
        dividend = a;
        divisor = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1;
        hi = '0;
        lo = '0;
        for (int n = 0; n <= 40; n++) begin
            @(negedge clk);
            if (done_o) begin
                lat = n;
                hi = hi_o;
                lo = lo_o;
                break;
            end
        end
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'h8000_0000;
            2: return '1;
            3: return W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        logic [W-1:0] hi, lo, q, r, ph, pl;

        ref_div(1'b1, 32'hFFFF_FFF9, 32'h2, q, r);
        check("pin_m7_2_lo", q, 32'hFFFF_FFFD);
        check("pin_m7_2_hi", r, 32'hFFFF_FFFF);
        ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, q, r);
        check("pin_ovf_lo", q, 32'h8000_0000);
        check("pin_ovf_hi", r, 32'h0);
        ref_div(1'b0, 32'hFFFF_FFF9, 32'h2, q, r);
        check("pin_u_lo", q, 32'h7FFF_FFFC);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_hi", hi_o, 32'd0);
        check("rst_lo", lo_o, 32'd0);

        do_op(1'b0, 32'd100, 32'd7, lat, hi, lo);
        check("divu_lat", W'(lat), 32'd33);
        check("divu_lo", lo, 32'h0000_000E);
        check("divu_hi", hi, 32'd2);

        do_op(1'b1, 32'hFFFF_FFF9, 32'h2, lat, hi, lo);
        check("div_m7_lo", lo, 32'hFFFF_FFFD);
        check("div_m7_hi", hi, 32'hFFFF_FFFF);

        do_op(1'b1, 32'd7, 32'hFFFF_FFFE, lat, hi, lo);
        check("div_7m2_lo", lo, 32'hFFFF_FFFD);
        check("div_7m2_hi", hi, 32'h1);

        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, hi, lo);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0);

        do_op(1'b0, 32'h1234_5678, 32'h0, lat, hi, lo);
        check("byz_lat", W'(lat), 32'd1);
        check("byz_lo", lo, 32'hFFFF_FFFF);
        check("byz_hi", hi, 32'h1234_5678);

        // Annul at edge k+10 of a 9/3 divide.
        ph = hi_o;
        pl = lo_o;
        @(posedge clk);
        #1;
        start = 1'b1;
        sgn = 1'b0;
        dividend = 32'd9;
        divisor = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        annul = 1'b1;
        @(posedge clk);
        #1;
        annul = 1'b0;
        @(negedge clk);
        check("annul_busy", {31'b0, busy_o}, 32'd0);
        check("annul_hi", hi_o, ph);
        check("annul_lo", lo_o, pl);
        do_op(1'b0, 32'd9, 32'd3, lat, hi, lo);
        check("post_annul_lat", W'(lat), 32'd33);
        check("post_annul_lo", lo, 32'd3);
        check("post_annul_hi", hi, 32'd0);

        // Start reasserted with new operands while busy must be ignored.
        @(posedge clk);
        #1;
        start = 1'b1;
        dividend = 32'd50;
        divisor = 32'd6;
        @(posedge clk);
        #1;
        dividend = 32'd1000;
        divisor = 32'd3;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done_o) begin
                lat = n;
                break;
            end
        end
        check("reassert_seen", {31'b0, lat > 0}, 32'd1);
        check("reassert_lo", lo_o, 32'd8);
        check("reassert_hi", hi_o, 32'd2);

        // Reset at edge k+5 of a second run.
        @(posedge clk);
        #1;
        start = 1'b1;
        dividend = 32'd50;
        divisor = 32'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", {31'b0, busy_o}, 32'd0);
        check("mid_rst_done", {31'b0, done_o}, 32'd0);
        check("mid_rst_hi", hi_o, 32'd0);
        check("mid_rst_lo", lo_o, 32'd0);
        repeat (40) @(posedge clk);

        for (int c = 0; c < 40000; c++) begin
            @(posedge clk);
            #1;
            start = ($urandom_range(0, 3) == 0);
            annul = ($urandom_range(0, 99) == 0);
            sgn = $urandom_range(0, 1) == 1;
            dividend = rnd_op();
            divisor = rnd_op();
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        annul = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
